fft_frame_rx: RTL and testbench



---
 rtl/fft_frame_rx.sv | 145 ++++++++++++++
 tb/tb_fft_frame_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_rx.sv
// ---------------------------------------------------------------------------
// fft_frame_rx : Avalon-ST receive framer; per-frame length, peak bin, errors
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_frame_rx #(
  parameter int FRAME_LEN = 50000,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_enable,
  input  logic              err_clr,
  input  logic              src_valid,
  input  logic              src_sop,
  input  logic              src_eop,
  input  logic [DATA_W-1:0] src_real,
  input  logic [DATA_W-1:0] src_imag,
  output logic              src_ready,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  peak_idx,
  output logic [DATA_W:0]   peak_mag,
  output logic              err_sop,
  output logic              err_len
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(FRAME_LEN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pk_idx_q, pk_idx_d;
  logic [DATA_W:0]   pk_mag_q, pk_mag_d;
  logic              src_ready_q, src_ready_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_len_q, frame_len_d;
  logic [CNT_W-1:0]  peak_idx_q, peak_idx_d;
  logic [DATA_W:0]   peak_mag_q, peak_mag_d;
  logic              err_sop_q, err_sop_d;
  logic              err_len_q, err_len_d;

  logic              accept;
  logic [DATA_W:0]   re_ext, im_ext, abs_re, abs_im, mag;
  logic [CNT_W-1:0]  cnt_inc;
  logic              mag_gt;

  // One extra bit keeps abs(-2^(DATA_W-1)) representable
  assign re_ext  = {src_real[DATA_W-1], src_real};
  assign im_ext  = {src_imag[DATA_W-1], src_imag};
  assign abs_re  = re_ext[DATA_W] ? (~re_ext + 1'b1) : re_ext;
  assign abs_im  = im_ext[DATA_W] ? (~im_ext + 1'b1) : im_ext;
  assign mag     = abs_re + abs_im;

  assign accept  = src_valid & src_ready_q;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign mag_gt  = mag > pk_mag_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pk_idx_d     = pk_idx_q;
    pk_mag_d     = pk_mag_q;
    src_ready_d  = rx_enable;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    err_sop_d    = err_clr ? 1'b0 : err_sop_q;
    err_len_d    = err_clr ? 1'b0 : err_len_q;

    if (accept) begin
      if (src_sop) begin
        // A sop always (re)starts a frame; inside a frame it also flags an error
        if (state_q == ST_FRAME) err_sop_d = 1'b1;
        cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
        pk_idx_d = '0;
        pk_mag_d = mag;
        state_d  = src_eop ? ST_IDLE : ST_FRAME;
      end else if (state_q == ST_IDLE) begin
        err_sop_d = 1'b1;
      end else begin
        if (mag_gt) begin
          pk_mag_d = mag;
          pk_idx_d = cnt_q;
        end
        cnt_d = cnt_inc;
        if (src_eop) state_d = ST_IDLE;
      end

      if (src_eop && (src_sop || state_q == ST_FRAME)) begin
        frame_done_d = 1'b1;
        frame_len_d  = cnt_d;
        peak_idx_d   = pk_idx_d;
        peak_mag_d   = pk_mag_d;
        if (cnt_d != C_FRAME_LEN) err_len_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pk_idx_q     <= '0;
      pk_mag_q     <= '0;
      src_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      err_sop_q    <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pk_idx_q     <= pk_idx_d;
      pk_mag_q     <= pk_mag_d;
      src_ready_q  <= src_ready_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      err_sop_q    <= err_sop_d;
      err_len_q    <= err_len_d;
    end
  end

  assign src_ready  = src_ready_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign peak_idx   = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign err_sop    = err_sop_q;
  assign err_len    = err_len_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_rx : directed stimulus with a frame-result scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_frame_rx;

  localparam int FRAME_LEN = 8;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 23;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_enable = 1'b0;
  logic              err_clr = 1'b0;
  logic              src_valid = 1'b0;
  logic              src_sop = 1'b0;
  logic              src_eop = 1'b0;
  logic [DATA_W-1:0] src_real = '0;
  logic [DATA_W-1:0] src_imag = '0;
  logic              src_ready;
  logic              frame_done;
  logic [CNT_W-1:0]  frame_len;
  logic [CNT_W-1:0]  peak_idx;
  logic [DATA_W:0]   peak_mag;
  logic              err_sop;
  logic              err_len;

  fft_frame_rx #(.FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .err_clr(err_clr),
    .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_real(src_real), .src_imag(src_imag), .src_ready(src_ready),
    .frame_done(frame_done), .frame_len(frame_len), .peak_idx(peak_idx),
    .peak_mag(peak_mag), .err_sop(err_sop), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int idx;
    int mag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_expect = 0;
  int   n_done   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every frame_done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_len", frame_len, e.len);
        chk("peak_idx", peak_idx, e.idx);
        chk("peak_mag", peak_mag, e.mag);
      end
    end
  end

  task automatic expect_frame(input int len, input int idx, input int mag);
    exp_t e;
    e.len = len; e.idx = idx; e.mag = mag;
    exp_q.push_back(e);
    n_expect++;
  endtask

  // Drive one beat and hold it until accepted; returns just after the accepting edge
  task automatic send(input bit sop, input bit eop, input int re, input int im);
    bit acc;
    int tries;
    src_valid = 1'b1; src_sop = sop; src_eop = eop;
    src_real = DATA_W'(re); src_imag = DATA_W'(im);
    acc = 1'b0; tries = 0;
    while (!acc) begin
      @(negedge clk);
      acc = src_ready;
      @(posedge clk); #1;
      tries++;
      if (!acc && tries > 50) begin
        chk("accept_timeout", 0, 1);
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_len"}, frame_len, 0);
    chk({tag, "_peak_idx"}, peak_idx, 0);
    chk({tag, "_peak_mag"}, peak_mag, 0);
    chk({tag, "_err_sop"}, err_sop, 0);
    chk({tag, "_err_len"}, err_len, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    rx_enable = 1'b1;
    idle(2);

    // Ramp frame: peak at the last bin
    expect_frame(8, 7, 7);
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, i, 0);
    idle(2);
    chk("ramp_err_len", err_len, 0);
    chk("ramp_err_sop", err_sop, 0);

    // Tie between bins 2 and 5 keeps bin 2; other bins mag 10 via mixed signs
    expect_frame(8, 2, 100);
    for (int i = 0; i < 8; i++)
      if (i == 2 || i == 5) send(i == 0, i == 7, 100, 0);
      else send(i == 0, i == 7, -7, 3);
    idle(1);

    // Most-negative components on bin 3
    expect_frame(8, 3, 65536);
    for (int i = 0; i < 8; i++)
      if (i == 3) send(i == 0, i == 7, -32768, -32768);
      else send(i == 0, i == 7, 10, 0);
    idle(2);
    chk("peak_err_len", err_len, 0);

    // Short frame: eop on the 6th beat
    expect_frame(6, 5, 5);
    for (int i = 0; i < 6; i++) send(i == 0, i == 5, i, 0);
    idle(2);
    chk("short_err_len_set", err_len, 1);
    pulse_clr();
    idle(1);
    chk("short_err_len_clr", err_len, 0);

    // err_clr in the same cycle as a new length error: set wins
    expect_frame(3, 1, 50);
    send(1, 0, 5, 0);
    send(0, 0, 0, 50);
    err_clr = 1'b1;
    send(0, 1, 20, -20);
    err_clr = 1'b0;
    idle(2);
    chk("clr_vs_set_err_len", err_len, 1);
    pulse_clr();
    idle(1);

    // Beats without sop in IDLE are dropped
    for (int i = 0; i < 3; i++) send(0, i == 2, 9, 9);
    idle(2);
    chk("nosop_err_sop", err_sop, 1);
    chk("nosop_no_done_count", n_done, n_expect - exp_q.size());

    // sop inside a frame restarts it
    expect_frame(8, 7, 8);
    for (int i = 0; i < 4; i++) send(i == 0, 0, 1000, 0);
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, i + 1, 0);
    idle(2);
    chk("restart_err_sop", err_sop, 1);
    chk("restart_err_len", err_len, 0);
    pulse_clr();
    idle(1);
    chk("restart_err_sop_clr", err_sop, 0);

    // rx_enable low for 5 cycles mid-frame, valid held high
    expect_frame(8, 7, 7);
    for (int i = 0; i < 4; i++) send(i == 0, 0, i, 0);
    rx_enable = 1'b0;
    src_real = DATA_W'(4);
    @(negedge clk);
    chk("stall_ready_still_high", src_ready, 1);
    @(posedge clk); #1;
    src_real = DATA_W'(5);
    @(negedge clk);
    chk("stall_ready_low", src_ready, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rx_enable = 1'b1;
    for (int i = 5; i < 8; i++) send(0, i == 7, i, 0);
    idle(2);
    chk("stall_err_len", err_len, 0);

    // Single-beat frame
    expect_frame(1, 0, 7);
    send(1, 1, 4, -3);
    idle(2);
    chk("single_err_len", err_len, 1);

    // Back-to-back frames with no bubble
    pulse_clr();
    expect_frame(8, 0, 30);
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, 30 - i, 0);
    expect_frame(8, 4, 40);
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, (i == 4) ? 40 : 1, 0);
    idle(2);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 3; i++) send(i == 0, 0, 500, 0);
    src_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    expect_frame(8, 7, 9);
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, i + 2, 0);
    idle(3);
    chk("post_rst_err_len", err_len, 0);
    chk("post_rst_err_sop", err_sop, 0);

    chk("outstanding_frames", exp_q.size(), 0);
    chk("frame_done_count", n_done, n_expect);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
